// File: rtl/conv_window_streamer.sv
// Streaming KxK sliding-window generator. Raster pixels enter one beat per
// cycle (CHANNELS lanes wide). K-1 previous rows live in line buffers, and a
// KxK window register per channel produces one window for every valid output
// position at stride 1 or 2. The window register also serves as the output
// register: while a window is pending and stalled, no new beat is taken, so
// the window cannot shift under the consumer.
module conv_window_streamer #(
  parameter int DATA_WIDTH     = 8,
  parameter int MAX_ROW_LENGTH = 64,
  parameter int KERNEL_SIZE    = 3,
  parameter int CHANNELS       = 1,
  parameter int DIM_W          = 7
) (
  input  logic                                                   clk,
  input  logic                                                   rst,
  input  logic                                                   start,
  input  logic [DIM_W-1:0]                                       cfg_width,
  input  logic [DIM_W-1:0]                                       cfg_height,
  input  logic                                                   cfg_stride,
  input  logic                                                   in_valid,
  output logic                                                   in_ready,
  input  logic [CHANNELS*DATA_WIDTH-1:0]                         din,
  output logic                                                   out_valid,
  input  logic                                                   out_ready,
  output logic [CHANNELS*KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] dout,
  output logic                                                   out_last,
  output logic                                                   busy,
  output logic                                                   frame_done,
  output logic                                                   cfg_err
);

  localparam int K  = KERNEL_SIZE;
  localparam int BW = CHANNELS * DATA_WIDTH;
  localparam int AW = (MAX_ROW_LENGTH > 1) ? $clog2(MAX_ROW_LENGTH) : 1;
  localparam logic [DIM_W-1:0] KM1 = DIM_W'(K - 1);
  localparam logic [DIM_W-1:0] ONE = DIM_W'(1);
  localparam logic [DIM_W-1:0] TWO = DIM_W'(2);
  localparam logic             K_ODD = ((K % 2) == 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_e;

  state_e           state_q, state_d;
  logic [DIM_W-1:0] width_q, height_q;
  logic             stride_q;
  logic [DIM_W-1:0] row_q, col_q;
  logic [DIM_W-1:0] last_row_q, last_col_q;
  logic             row_ph_q, col_ph_q;
  logic             out_valid_q, out_last_q, frame_done_q, cfg_err_q;

  logic [BW-1:0] line_q [K-1][MAX_ROW_LENGTH];
  logic [BW-1:0] win_q  [K][K];
  logic [BW-1:0] col_vec [K];

  logic          cfg_ok, launch, err_set, finish, accept, rdy;
  logic          col_wrap, frame_end, emit, is_last;
  logic [AW-1:0] col_addr;

  assign cfg_ok = (int'(cfg_width) >= K) && (int'(cfg_width) <= MAX_ROW_LENGTH) &&
                  (int'(cfg_height) >= K);
  assign col_addr  = col_q[AW-1:0];
  assign col_wrap  = (col_q == width_q - ONE);
  assign frame_end = col_wrap && (row_q == height_q - ONE);
  // Stride phases are 0 on every emitting row/column; stride 1 ignores them.
  assign emit      = (row_q >= KM1) && (col_q >= KM1) &&
                     (!stride_q || (!row_ph_q && !col_ph_q));
  assign is_last   = (row_q == last_row_q) && (col_q == last_col_q);

  // Next-state and handshake decode for the frame controller.
  always_comb begin
    // NOTE: every signal driven here gets a default first so no path can leave it unassigned and infer a latch.
    state_d = state_q;
    launch  = 1'b0;
    err_set = 1'b0;
    finish  = 1'b0;
    rdy     = 1'b0;
    accept  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (cfg_ok) begin
            launch  = 1'b1;
            state_d = S_RUN;
          end else begin
            err_set = 1'b1;
          end
        end
      end
      S_RUN: begin
        rdy    = !out_valid_q || out_ready;
        accept = in_valid && rdy;
        if (accept && frame_end) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        // Only the out_last window can still be pending here.
        if (!out_valid_q || out_ready) begin
          finish  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Column of K pixels for the current column: K-1 buffered rows plus the new beat.
  always_comb begin
    for (int k = 0; k < K - 1; k++) col_vec[k] = line_q[k][col_addr];
    col_vec[K-1] = din;
  end

  // Frame controller state, configuration, counters and output flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      state_q      <= S_IDLE;
      width_q      <= '0;
      height_q     <= '0;
      stride_q     <= 1'b0;
      row_q        <= '0;
      col_q        <= '0;
      last_row_q   <= '0;
      last_col_q   <= '0;
      row_ph_q     <= 1'b0;
      col_ph_q     <= 1'b0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      frame_done_q <= 1'b0;
      cfg_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      frame_done_q <= finish;
      if (launch)       cfg_err_q <= 1'b0;
      else if (err_set) cfg_err_q <= 1'b1;

      if (launch) begin
        width_q    <= cfg_width;
        height_q   <= cfg_height;
        stride_q   <= cfg_stride;
        row_q      <= '0;
        col_q      <= '0;
        row_ph_q   <= 1'b0;
        col_ph_q   <= 1'b0;
        // At stride 2 with (dim-K) odd the final emitting row/column is dim-2.
        last_row_q <= cfg_height - ((cfg_stride && (cfg_height[0] ^ K_ODD)) ? TWO : ONE);
        last_col_q <= cfg_width  - ((cfg_stride && (cfg_width[0]  ^ K_ODD)) ? TWO : ONE);
      end else if (accept) begin
        if (col_wrap) begin
          col_q    <= '0;
          col_ph_q <= 1'b0;
          row_q    <= row_q + ONE;
          if (row_q >= KM1) row_ph_q <= ~row_ph_q;
        end else begin
          col_q <= col_q + ONE;
          if (col_q >= KM1) col_ph_q <= ~col_ph_q;
        end
      end

      if (accept) begin
        out_valid_q <= emit;
        out_last_q  <= emit && is_last;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
      end
    end
  end

  // Row buffers: each column slot shifts up one row and takes the new pixel.
  always_ff @(posedge clk) begin
    // NOTE: buffer storage has no reset; stale rows are never emitted because no window forms before row K-1.
    if (accept) begin
      for (int k = 0; k < K - 2; k++) line_q[k][col_addr] <= line_q[k+1][col_addr];
      line_q[K-2][col_addr] <= din;
    end
  end

  // Window register: shift left by one column and load the new column on the right.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < K; r++)
        for (int c = 0; c < K; c++) win_q[r][c] <= '0;
    end else if (accept) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K - 1; c++) win_q[r][c] <= win_q[r][c+1];
        win_q[r][K-1] <= col_vec[r];
      end
    end
  end

  // Flatten the window; each (r,c) slot holds all channel lanes of one beat.
  always_comb begin
    dout = '0;
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++) dout[(r*K+c)*BW +: BW] = win_q[r][c];
  end

  assign in_ready   = rdy;
  assign out_valid  = out_valid_q;
  assign out_last   = out_last_q;
  assign busy       = (state_q != S_IDLE);
  assign frame_done = frame_done_q;
  assign cfg_err    = cfg_err_q;

endmodule

// File: tb/tb_conv_window_streamer.sv
// Self-checking bench for conv_window_streamer (K=3, two channels).
// Expected windows are enumerated from the image array and queued before each
// frame starts; a negedge monitor pops and compares every accepted window.
module tb_conv_window_streamer;

  localparam int DW    = 8;
  localparam int K     = 3;
  localparam int CH    = 2;
  localparam int MAXW  = 64;
  localparam int DIM_W = 7;
  localparam int OW    = CH * K * K * DW;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [DIM_W-1:0] cfg_width = '0;
  logic [DIM_W-1:0] cfg_height = '0;
  logic             cfg_stride = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [CH*DW-1:0] din = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [OW-1:0]    dout;
  logic             out_last, busy, frame_done, cfg_err;

  conv_window_streamer #(
    .DATA_WIDTH(DW), .MAX_ROW_LENGTH(MAXW), .KERNEL_SIZE(K), .CHANNELS(CH), .DIM_W(DIM_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_width(cfg_width), .cfg_height(cfg_height),
    .cfg_stride(cfg_stride), .in_valid(in_valid), .in_ready(in_ready), .din(din),
    .out_valid(out_valid), .out_ready(out_ready), .dout(dout), .out_last(out_last),
    .busy(busy), .frame_done(frame_done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct { logic [OW-1:0] win; logic last; } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  logic [7:0] img [CH][16][MAXW];
  int         n_checks = 0;
  int         n_fail = 0;
  int         rx_cnt = 0;
  int         done_cnt = 0;
  int         chk_at = -1;
  int         ready_mode = 0;
  int         rdy_ph = 0;

  task automatic check(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference window: pixel (r-K+1+i, c-K+1+j) of channel ch at its documented bit slot.
  function automatic logic [OW-1:0] window(input int r, input int c);
    logic [OW-1:0] w;
    w = '0;
    for (int i = 0; i < K; i++)
      for (int j = 0; j < K; j++)
        for (int ch = 0; ch < CH; ch++)
          w[((i*K+j)*CH+ch)*DW +: DW] = img[ch][r-K+1+i][c-K+1+j];
    return w;
  endfunction

  function automatic bit emit_at(input int r, input int c, input int s);
    return (r >= K-1) && (c >= K-1) && ((r-K+1) % s == 0) && ((c-K+1) % s == 0);
  endfunction

  // Consumer ready pattern: always, 1-0-0 repeating, or random.
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      1:       out_ready = (rdy_ph % 3) == 0;
      2:       out_ready = ($urandom_range(0, 1) == 1);
      default: out_ready = 1'b1;
    endcase
    rdy_ph++;
  end

  // Monitor: scoreboard pops, stall-hold checks and frame_done counting.
  logic          prev_stall = 1'b0;
  logic [OW-1:0] prev_dout = '0;
  logic          prev_last = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      prev_stall = 1'b0;
    end else begin
      if (frame_done) done_cnt++;
      if (prev_stall) begin
        check("hold_valid", OW'(out_valid), OW'(1));
        check("hold_dout", dout, prev_dout);
        check("hold_last", OW'(out_last), OW'(prev_last));
      end
      if (out_valid && !out_ready) check("stall_in_ready", OW'(in_ready), OW'(0));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_window: got %h expected none", dout);
        end else begin
          mon_e = exp_q.pop_front();
          check("window", dout, mon_e.win);
          check("last", OW'(out_last), OW'(mon_e.last));
          if (rx_cnt == chk_at) check("ch1_r1_c2", OW'(dout[(5*2+1)*DW +: DW]), OW'(107));
        end
        rx_cnt++;
      end
      prev_stall = out_valid && !out_ready;
      prev_dout  = dout;
      prev_last  = out_last;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int w, input int h, input int s);
    start      = 1'b1;
    cfg_width  = DIM_W'(w);
    cfg_height = DIM_W'(h);
    cfg_stride = (s == 2);
    tick();
    start = 1'b0;
  endtask

  task automatic run_frame(input int w, input int h, input int s, input int mode,
                           input bit rnd, input bit gaps, input int abort_after, input bit chk);
    int   base_rx, base_done, acc, guard, exp_n, r, c;
    bit   got, pend, pend_emit, aborted;
    exp_t e;
    for (int i = 0; i < h; i++)
      for (int j = 0; j < w; j++) begin
        img[0][i][j] = rnd ? 8'($urandom) : 8'(i*w + j);
        img[1][i][j] = rnd ? 8'($urandom) : 8'(100 + i*w + j);
      end
    for (int i = K-1; i < h; i += s)
      for (int j = K-1; j < w; j += s) begin
        e.win  = window(i, j);
        e.last = 1'b0;
        exp_q.push_back(e);
      end
    exp_q[exp_q.size()-1].last = 1'b1;
    exp_n      = ((w-K)/s + 1) * ((h-K)/s + 1);
    ready_mode = mode;
    base_rx    = rx_cnt;
    base_done  = done_cnt;
    chk_at     = chk ? rx_cnt : -1;

    do_start(w, h, s);
    @(negedge clk);
    check("start_busy", OW'(busy), OW'(1));
    check("start_cfg_err", OW'(cfg_err), OW'(0));
    tick();

    acc = 0; aborted = 0; pend = 0; pend_emit = 0;
    for (int idx = 0; idx < w*h; idx++) begin
      r = idx / w;
      c = idx % w;
      if (gaps && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        @(negedge clk);
        if (pend) begin check("emit_latency", OW'(out_valid), OW'(pend_emit)); pend = 0; end
        tick();
      end
      in_valid = 1'b1;
      din      = {img[1][r][c], img[0][r][c]};
      if (idx == 7) begin
        // A bad start while running must be ignored entirely.
        start = 1'b1; cfg_width = DIM_W'(1); cfg_height = DIM_W'(1); cfg_stride = 1'b0;
      end
      got = 0; guard = 0;
      while (!got && guard < 200) begin
        @(negedge clk);
        if (pend) begin check("emit_latency", OW'(out_valid), OW'(pend_emit)); pend = 0; end
        got = in_ready;
        guard++;
        tick();
        start = 1'b0;
      end
      if (!got) begin
        n_checks++; n_fail++;
        $display("FAIL accept_timeout: got no in_ready expected in_ready at pixel %0d", idx);
        break;
      end
      acc++;
      if (mode == 0) begin pend = 1; pend_emit = emit_at(r, c, s); end
      if (acc == abort_after) begin aborted = 1; break; end
    end
    in_valid = 1'b0;

    if (aborted) begin
      #2 rst = 1'b0;
      #1;
      check("rst_out_valid", OW'(out_valid), OW'(0));
      check("rst_in_ready", OW'(in_ready), OW'(0));
      check("rst_busy", OW'(busy), OW'(0));
      check("rst_out_last", OW'(out_last), OW'(0));
      check("rst_frame_done", OW'(frame_done), OW'(0));
      check("rst_cfg_err", OW'(cfg_err), OW'(0));
      check("rst_dout", dout, OW'(0));
      exp_q.delete();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      repeat (5) tick();
      check("abort_idle", OW'(busy), OW'(0));
      check("abort_no_done", OW'(done_cnt), OW'(base_done));
      return;
    end

    if (pend) begin
      @(negedge clk);
      check("emit_latency", OW'(out_valid), OW'(pend_emit));
    end
    guard = 0;
    while (!frame_done && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("frame_done", OW'(frame_done), OW'(1));
    check("done_idle", OW'(busy), OW'(0));
    check("done_in_ready", OW'(in_ready), OW'(0));
    check("window_count", OW'(rx_cnt - base_rx), OW'(exp_n));
    check("queue_empty", OW'(exp_q.size()), OW'(0));
    check("cfg_err_clear", OW'(cfg_err), OW'(0));
    @(negedge clk);
    check("done_pulse", OW'(frame_done), OW'(0));
    exp_q.delete();
    tick();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w, h, s, mode;
    #1 rst = 1'b0;
    #2;
    check("reset_out_valid", OW'(out_valid), OW'(0));
    check("reset_in_ready", OW'(in_ready), OW'(0));
    check("reset_busy", OW'(busy), OW'(0));
    check("reset_frame_done", OW'(frame_done), OW'(0));
    check("reset_cfg_err", OW'(cfg_err), OW'(0));
    check("reset_dout", dout, OW'(0));
    @(negedge clk);
    rst = 1'b1;
    tick();

    // Beats offered while idle are ignored.
    in_valid = 1'b1;
    din      = 16'($urandom);
    repeat (2) begin
      @(negedge clk);
      check("idle_in_ready", OW'(in_ready), OW'(0));
      check("idle_out_valid", OW'(out_valid), OW'(0));
      tick();
    end
    in_valid = 1'b0;

    run_frame(5, 5, 1, 0, 0, 0, -1, 1);   // stride 1, both channels, ch1 slot check
    run_frame(5, 5, 2, 0, 0, 0, -1, 0);   // stride 2
    run_frame(5, 5, 1, 1, 0, 0, -1, 0);   // backpressure 1,0,0,...

    // Configuration errors, then a good start clears the flag.
    do_start(2, 5, 0);
    @(negedge clk);
    check("err_w_small", OW'(cfg_err), OW'(1));
    check("err_busy", OW'(busy), OW'(0));
    check("err_in_ready", OW'(in_ready), OW'(0));
    tick();
    do_start(65, 5, 0);
    @(negedge clk);
    check("err_w_large_busy", OW'(busy), OW'(0));
    tick();
    do_start(5, 2, 1);
    @(negedge clk);
    check("err_h_small_busy", OW'(busy), OW'(0));
    check("err_sticky", OW'(cfg_err), OW'(1));
    tick();
    run_frame(5, 5, 1, 0, 0, 0, -1, 0);

    // Boundaries: widest row, minimum height, single-window frame.
    run_frame(64, 3, 2, 2, 1, 1, -1, 0);
    run_frame(3, 3, 2, 0, 1, 0, -1, 0);
    run_frame(6, 6, 2, 2, 1, 1, -1, 0);

    // Reset after 15 pixels, then the stride 1 frame must reproduce exactly.
    run_frame(5, 5, 1, 0, 0, 0, 15, 0);
    run_frame(5, 5, 1, 0, 0, 0, -1, 1);

    repeat (8) begin
      w    = $urandom_range(K, 12);
      h    = $urandom_range(K, 10);
      s    = $urandom_range(1, 2);
      mode = $urandom_range(0, 2);
      run_frame(w, h, s, mode, 1, (mode != 0), -1, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/conv_window_streamer.md
Name: conv_window_streamer

Overview:
- Streaming sliding-window generator feeding the convolution MAC array.
- Accepts a raster-order pixel stream (CHANNELS lanes per beat) and buffers K-1 full rows plus a KxK window register per channel.
- Emits one KxK window per channel for every valid output position, with runtime image width/height and stride 1 or 2.
- Valid/ready handshakes on both sides, frame start/done control, and config error detection.

Parameters:
- DATA_WIDTH, 8, bits per pixel per channel.
- MAX_ROW_LENGTH, 64, maximum image width; sizes the row buffers.
- KERNEL_SIZE, 3, window side K (allowed 2..7).
- CHANNELS, 1, parallel channels per input beat.
- DIM_W, 7, width of the cfg_width and cfg_height fields.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; latches cfg_* and begins a frame (honoured only in IDLE).
- cfg_width  in  DIM_W  image width W.
- cfg_height  in  DIM_W  image height H.
- cfg_stride  in  1  0 = stride 1, 1 = stride 2.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- din  in  CHANNELS*DATA_WIDTH  pixel; channel ch occupies bits [ch*DATA_WIDTH +: DATA_WIDTH].
- out_valid  out  1  window valid.
- out_ready  in  1  consumer accepts the window.
- dout  out  CHANNELS*K*K*DATA_WIDTH  window; element (ch,r,c) occupies bits [((r*K+c)*CHANNELS+ch)*DATA_WIDTH +: DATA_WIDTH]; r=0 is the top (oldest) row, c=0 the leftmost column.
- out_last  out  1  qualifies the final window of the frame.
- busy  out  1  high in RUN or DRAIN.
- frame_done  out  1  one-cycle pulse at frame completion.
- cfg_err  out  1  sticky; cleared by the next accepted start.

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0. Row-buffer contents need not be cleared.
- States: IDLE, RUN, DRAIN.
- IDLE:
  - in_ready=0.
  - start with K<=W<=MAX_ROW_LENGTH and K<=H: latch config, clear row/col counters, go to RUN.
  - start with any violation: set cfg_err=1 and stay in IDLE.
- RUN:
  - in_ready = !out_valid || out_ready (one-deep output register; full-throughput skid-free).
  - An input beat is accepted when in_valid && in_ready.
  - On accept at (row,col): shift the pixel into the row buffers and window, then advance col; at col=W-1 wrap col to 0 and increment row.
- Window emit rule: the window whose bottom-right pixel is (row,col) is emitted when all of these hold:
  - row>=K-1 and col>=K-1;
  - (row-(K-1)) mod S == 0;
  - (col-(K-1)) mod S == 0.
  - Implement the mod tests with stride phase counters, not division.
- Latency: out_valid rises the cycle after the accepting edge.
- Hold: dout, out_valid and out_last hold stable until out_valid && out_ready.
- Window count per frame: ((W-K)/S+1)*((H-K)/S+1), integer division. There is no padding, and windows never straddle a row boundary.
- out_last is set on the emitted window with the largest (row,col).
- Exit from RUN: accepting pixel (H-1,W-1) moves to DRAIN; in_ready=0 from the next cycle.
- DRAIN: when no window is pending, or on the handshake of the out_last window, pulse frame_done for one cycle and return to IDLE.
- Unaccepted beats: in_valid while in_ready=0 is not consumed. Beats offered in IDLE or DRAIN are ignored.
- start in RUN or DRAIN is ignored and does not set cfg_err.
- Simultaneous output handshake and new emit in the same cycle: the register is replaced with no bubble.
- Asynchronous reset mid-frame aborts immediately. frame_done does not pulse, and the next frame requires a new start.
- Channels are independent; all lanes share the counters and handshakes.

Test Plan:
- Basic stride 1: K=3, CH=1, W=H=5, S=1, pixel = row*5+col, out_ready=1.
  - Exactly 9 windows, issued one cycle after pixels 12,13,14,17,...,24.
  - First dout = {0,1,2,5,6,7,10,11,12} (index 0..8).
  - out_last on the window with element 8 = 24; frame_done follows.
- Stride 2: same image, S=1 replaced by S=2.
  - 4 windows with bottom-right pixels 12, 14, 22, 24.
  - Second window = {2,3,4,7,8,9,12,13,14}.
- Backpressure: same as the stride 1 case with out_ready toggling 1,0,0,1,...
  - in_ready=0 whenever out_valid && !out_ready.
  - dout stable during stall; all 9 windows in order; none lost or duplicated.
- Multi-channel: CH=2, ch0 = row*5+col, ch1 = 100+row*5+col, W=H=5, S=1.
  - First window element (ch1,r=1,c=2) = 107, at bits [(5*2+1)*8 +: 8].
- Config error: start with W=2, H=5.
  - cfg_err=1, busy=0, in_ready=0.
  - A following valid start (W=H=5) clears cfg_err and runs normally.
- Reset mid-frame: assert rst after 15 pixels.
  - All outputs 0 immediately, state IDLE, no frame_done.
  - A new start with the stride 1 stimulus reproduces the stride 1 results exactly.
